// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
//   state_t   : sequencing FSM states
//   opcodes   : RV32I major opcodes recognised by the core
//   alu_op_t  : ALU operation code driven on alu_op
//   pc_sel_t  : next-PC source select
//   wb_sel_t  : register write-back source select
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_t;

    // Arithmetic/logic op for OP and OP-IMM. funct7[5] only selects SUB for
    // register ops; for shifts it selects arithmetic right in both forms.
    function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                           input logic       funct7_b5,
                                           input logic       is_reg);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Comparison the ALU performs so it can produce branch_taken.
    function automatic alu_op_t branch_alu_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'b100, 3'b101: op = ALU_SLT;
            3'b110, 3'b111: op = ALU_SLTU;
            default:        op = ALU_SUB;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_control_imm_gen.sv
// Immediate generator: decodes the I/S/B/U/J immediate from the instruction
// according to its opcode and sign-extends it to XLEN (XLEN >= 32).
// Opcodes without an immediate (OP, unknown) produce 0.
//   instr : instruction word
//   imm   : sign-extended immediate
module imm_gen
    import multicycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm_raw;

    always_comb begin
        imm_raw = '0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR:
                imm_raw = {{20{instr[31]}}, instr[31:20]};
            STORE:
                imm_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:
                imm_raw = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:
                imm_raw = {instr[31:12], 12'b0};
            JAL:
                imm_raw = {{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
            default:
                imm_raw = '0;
        endcase
        imm = XLEN'(imm_raw);
    end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multi-cycle RV32I core.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   instr                    : instruction register contents
//   mem_ready                : memory handshake completion
//   branch_taken             : ALU branch-compare result (EXECUTE)
//   mem_req/mem_we/mem_addr_sel : shared memory port control
//   ir_load, pc_load, pc_sel : IR/PC update control
//   rf_rs1/rf_rs2/rf_rd/rf_write : register file control
//   alu_op, alu_src_a, alu_src_b : ALU control
//   wb_sel                   : write-back source
//   imm                      : sign-extended immediate
//   illegal, bus_err         : sticky error flags
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_addr_sel,
    output logic            ir_load,
    output logic            pc_load,
    output logic [1:0]      pc_sel,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    output logic [4:0]      rf_rd,
    output logic            rf_write,
    output logic [3:0]      alu_op,
    output logic            alu_src_a,
    output logic            alu_src_b,
    output logic [1:0]      wb_sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal,
    output logic            bus_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // A wait cycle seen with the counter at this value would make it reach
    // MEM_TIMEOUT, so that is where the request is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    // Low for the first FETCH cycle after reset so every output reads 0 on
    // the cycle after rst is sampled, as the memory side expects.
    logic             req_en_q, req_en_d;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  imm_dec;
    logic             waiting;
    alu_op_t          alu_op_e;
    pc_sel_t          pc_sel_e;
    wb_sel_t          wb_sel_e;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (instr),
        .imm   (imm_dec)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        req_en_d     = 1'b1;
        waiting      = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        pc_sel_e     = PC_PLUS4;
        rf_rs1       = '0;
        rf_rs2       = '0;
        rf_rd        = '0;
        rf_write     = 1'b0;
        alu_op_e     = ALU_ADD;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        wb_sel_e     = WB_ALU;
        imm          = '0;

        // Source addresses and immediate are presented from DECODE until the
        // instruction retires; instr is stable over that whole window.
        if (state_q inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK}) begin
            rf_rs1 = instr[19:15];
            rf_rs2 = instr[24:20];
            imm    = imm_dec;
        end

        case (state_q)
            S_FETCH: begin
                if (req_en_q) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        state_d = S_DECODE;
                    end else begin
                        waiting = 1'b1;
                    end
                end
            end

            S_DECODE: begin
                state_d = S_EXECUTE;
            end

            S_EXECUTE: begin
                case (opcode)
                    OP: begin
                        alu_op_e = alu_decode(funct3, instr[30], 1'b1);
                        state_d  = S_WRITEBACK;
                    end
                    OP_IMM: begin
                        alu_op_e  = alu_decode(funct3, instr[30], 1'b0);
                        alu_src_b = 1'b1;
                        state_d   = S_WRITEBACK;
                    end
                    LUI: begin
                        alu_op_e  = ALU_PASS_B;
                        alu_src_b = 1'b1;
                        state_d   = S_WRITEBACK;
                    end
                    AUIPC, JAL: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        state_d   = S_WRITEBACK;
                    end
                    JALR: begin
                        alu_src_b = 1'b1;
                        state_d   = S_WRITEBACK;
                    end
                    LOAD, STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    BRANCH: begin
                        alu_op_e = branch_alu_op(funct3);
                        pc_load  = 1'b1;
                        pc_sel_e = branch_taken ? PC_IMM : PC_PLUS4;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == STORE);
                if (mem_ready) begin
                    if (opcode == STORE) begin
                        pc_load = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end

            S_WRITEBACK: begin
                rf_rd    = instr[11:7];
                rf_write = (instr[11:7] != 5'd0);
                pc_load  = 1'b1;
                if (opcode == LOAD) begin
                    wb_sel_e = WB_LOAD;
                end else if (opcode == JAL || opcode == JALR) begin
                    wb_sel_e = WB_PC4;
                    pc_sel_e = PC_ALU;
                end
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (waiting) begin
            if (MEM_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                bus_err_d = 1'b1;
                state_d   = S_HALT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign pc_sel  = pc_sel_e;
    assign alu_op  = alu_op_e;
    assign wb_sel  = wb_sel_e;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            req_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            req_en_q  <= req_en_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step drives inputs, pushes the
// expected output vector onto a scoreboard and pops/compares it at negedge.
module tb_multicycle_control;
    import multicycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready, branch_taken;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_load;
    logic [1:0]  pc_sel;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic        rf_write;
    logic [3:0]  alu_op;
    logic        alu_src_a, alu_src_b;
    logic [1:0]  wb_sel;
    logic [31:0] imm;
    logic        illegal, bus_err;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        mem_addr_sel;
        logic        ir_load;
        logic        pc_load;
        logic [1:0]  pc_sel;
        logic [4:0]  rf_rs1;
        logic [4:0]  rf_rs2;
        logic [4:0]  rf_rd;
        logic        rf_write;
        logic [3:0]  alu_op;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [1:0]  wb_sel;
        logic [31:0] imm;
        logic        illegal;
        logic        bus_err;
    } outs_t;

    typedef struct {
        string tag;
        outs_t e;
    } sb_t;

    sb_t   sb[$];
    int    tests_run    = 0;
    int    tests_failed = 0;
    outs_t e;
    outs_t z = '0;

    multicycle_control #(
        .XLEN        (32),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .pc_load      (pc_load),
        .pc_sel       (pc_sel),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_rd        (rf_rd),
        .rf_write     (rf_write),
        .alu_op       (alu_op),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .wb_sel       (wb_sel),
        .imm          (imm),
        .illegal      (illegal),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, tests run %0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    function automatic outs_t held(input logic [4:0] r1, input logic [4:0] r2,
                                   input logic [31:0] im);
        outs_t t = '0;
        t.rf_rs1 = r1;
        t.rf_rs2 = r2;
        t.imm    = im;
        return t;
    endfunction

    task automatic check_front();
        sb_t   s;
        outs_t a;
        s = sb.pop_front();
        a = {mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel,
             rf_rs1, rf_rs2, rf_rd, rf_write, alu_op, alu_src_a, alu_src_b,
             wb_sel, imm, illegal, bus_err};
        tests_run++;
        assert (a === s.e) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", s.tag, a, s.e);
        end
    endtask

    // One clock cycle: drive inputs just after posedge, compare at negedge.
    task automatic cyc(input string tag, input logic rdy, input logic bt,
                       input outs_t exp_o);
        sb_t s;
        mem_ready    = rdy;
        branch_taken = bt;
        s.tag = tag;
        s.e   = exp_o;
        sb.push_back(s);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok(input string tag);
        outs_t t = '0;
        t.mem_req = 1'b1;
        t.ir_load = 1'b1;
        cyc(tag, 1'b1, 1'b0, t);
    endtask

    initial begin
        rst          = 1'b1;
        instr        = '0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_hold", 1'b0, 1'b0, z);
        rst = 1'b0;
        cyc("reset_settle", 1'b1, 1'b0, z);

        // ADDI x1,x0,5
        instr = 32'h00500093;
        fetch_ok("addi1_fetch");
        e = held(5'd0, 5'd5, 32'd5);
        cyc("addi1_decode", 1'b1, 1'b0, e);
        e.alu_op = ALU_ADD; e.alu_src_b = 1'b1;
        cyc("addi1_exec", 1'b1, 1'b0, e);
        e = held(5'd0, 5'd5, 32'd5);
        e.rf_rd = 5'd1; e.rf_write = 1'b1; e.pc_load = 1'b1;
        cyc("addi1_wb", 1'b1, 1'b0, e);

        // ADDI x0,x0,5: no register write
        instr = 32'h00500013;
        fetch_ok("addi0_fetch");
        e = held(5'd0, 5'd5, 32'd5);
        cyc("addi0_decode", 1'b1, 1'b0, e);
        e.alu_src_b = 1'b1;
        cyc("addi0_exec", 1'b1, 1'b0, e);
        e = held(5'd0, 5'd5, 32'd5);
        e.pc_load = 1'b1;
        cyc("addi0_wb", 1'b1, 1'b0, e);

        // SUB x3,x1,x2
        instr = 32'h402081B3;
        fetch_ok("sub_fetch");
        e = held(5'd1, 5'd2, 32'd0);
        cyc("sub_decode", 1'b1, 1'b0, e);
        e.alu_op = ALU_SUB;
        cyc("sub_exec", 1'b1, 1'b0, e);
        e = held(5'd1, 5'd2, 32'd0);
        e.rf_rd = 5'd3; e.rf_write = 1'b1; e.pc_load = 1'b1;
        cyc("sub_wb", 1'b1, 1'b0, e);

        // LW x2,8(x1) with mem_ready delayed 3 cycles in MEM
        instr = 32'h0080A103;
        fetch_ok("lw_fetch");
        e = held(5'd1, 5'd8, 32'd8);
        cyc("lw_decode", 1'b1, 1'b0, e);
        e.alu_src_b = 1'b1;
        cyc("lw_exec", 1'b1, 1'b0, e);
        e = held(5'd1, 5'd8, 32'd8);
        e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, 1'b0, e);
        cyc("lw_mem_done", 1'b1, 1'b0, e);
        e = held(5'd1, 5'd8, 32'd8);
        e.rf_rd = 5'd2; e.rf_write = 1'b1; e.wb_sel = 2'd1; e.pc_load = 1'b1;
        cyc("lw_wb", 1'b1, 1'b0, e);

        // SW x2,4(x1), zero-wait
        instr = 32'h0020A223;
        fetch_ok("sw_fetch");
        e = held(5'd1, 5'd2, 32'd4);
        cyc("sw_decode", 1'b1, 1'b0, e);
        e.alu_src_b = 1'b1;
        cyc("sw_exec", 1'b1, 1'b0, e);
        e = held(5'd1, 5'd2, 32'd4);
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1; e.pc_load = 1'b1;
        cyc("sw_mem", 1'b1, 1'b0, e);

        // BEQ x1,x2,+8 taken
        instr = 32'h00208463;
        fetch_ok("beq_fetch");
        e = held(5'd1, 5'd2, 32'd8);
        cyc("beq_decode", 1'b1, 1'b0, e);
        e.alu_op = ALU_SUB; e.pc_load = 1'b1; e.pc_sel = 2'd1;
        cyc("beq_exec", 1'b1, 1'b1, e);

        // BNE x1,x2,+8 not taken
        instr = 32'h00209463;
        fetch_ok("bne_fetch");
        e = held(5'd1, 5'd2, 32'd8);
        cyc("bne_decode", 1'b1, 1'b0, e);
        e.alu_op = ALU_SUB; e.pc_load = 1'b1;
        cyc("bne_exec", 1'b1, 1'b0, e);

        // JAL x1,+16
        instr = 32'h010000EF;
        fetch_ok("jal_fetch");
        e = held(5'd0, 5'd16, 32'd16);
        cyc("jal_decode", 1'b1, 1'b0, e);
        e.alu_src_a = 1'b1; e.alu_src_b = 1'b1;
        cyc("jal_exec", 1'b1, 1'b0, e);
        e = held(5'd0, 5'd16, 32'd16);
        e.rf_rd = 5'd1; e.rf_write = 1'b1; e.wb_sel = 2'd2;
        e.pc_load = 1'b1; e.pc_sel = 2'd2;
        cyc("jal_wb", 1'b1, 1'b0, e);

        // Illegal opcode: HALT, ignores mem_ready until rst
        instr = 32'h00000000;
        fetch_ok("ill_fetch");
        cyc("ill_decode", 1'b1, 1'b0, z);
        cyc("ill_exec", 1'b1, 1'b0, z);
        e = z; e.illegal = 1'b1;
        for (int i = 0; i < 4; i++) cyc("ill_halt", i[0], 1'b0, e);
        rst = 1'b1;
        cyc("ill_rst_assert", 1'b1, 1'b0, e);
        cyc("ill_rst_hold", 1'b1, 1'b0, z);
        rst = 1'b0;
        cyc("ill_rst_settle", 1'b0, 1'b0, z);

        // FETCH timeout with MEM_TIMEOUT=4
        e = z; e.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc("to_fetch_wait", 1'b0, 1'b0, e);
        e = z; e.bus_err = 1'b1;
        cyc("to_halt", 1'b1, 1'b0, e);
        cyc("to_halt_hold", 1'b0, 1'b0, e);
        rst = 1'b1;
        cyc("to_rst_assert", 1'b0, 1'b0, e);
        cyc("to_rst_hold", 1'b0, 1'b0, z);
        rst = 1'b0;
        cyc("to_rst_settle", 1'b0, 1'b0, z);

        // rst during MEM wait of a load
        instr = 32'h0080A103;
        fetch_ok("lwr_fetch");
        e = held(5'd1, 5'd8, 32'd8);
        cyc("lwr_decode", 1'b1, 1'b0, e);
        e.alu_src_b = 1'b1;
        cyc("lwr_exec", 1'b1, 1'b0, e);
        e = held(5'd1, 5'd8, 32'd8);
        e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
        cyc("lwr_mem_wait", 1'b0, 1'b0, e);
        rst = 1'b1;
        cyc("lwr_mem_rst", 1'b0, 1'b0, e);
        tests_run++;
        assert (dut.state_q === S_FETCH) else begin
            tests_failed++;
            $error("FAIL lwr_state_after_rst: observed=%0d expected=%0d",
                   dut.state_q, S_FETCH);
        end
        cyc("lwr_req_dropped", 1'b0, 1'b0, z);
        rst = 1'b0;
        cyc("lwr_rst_settle", 1'b0, 1'b0, z);
        fetch_ok("lwr_refetch");
        e = held(5'd1, 5'd8, 32'd8);
        cyc("lwr_redecode", 1'b0, 1'b0, e);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main sequencing FSM for the multi-cycle RV32I core. Decodes the latched instruction and drives the register_file read addresses, the write_register strobe, the ALU/PC/writeback muxes and the single shared instruction/data memory port. Sits between the instruction register and the datapath; it holds no architectural state except its FSM state, the memory-timeout counter and the sticky error flags.

Parameters:
XLEN, 32, datapath width; the immediate output width.
MEM_TIMEOUT, 255, maximum wait cycles for mem_ready per request; 0 disables the timeout.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high.
instr  input  32  instruction register contents; stable from DECODE until the next ir_load.
mem_ready  input  1  memory handshake completion, sampled only while mem_req=1.
branch_taken  input  1  ALU branch-compare result, valid in EXECUTE.
mem_req  output  1  memory request; held until mem_ready.
mem_we  output  1  store request qualifier.
mem_addr_sel  output  1  0=PC, 1=ALU result register.
ir_load  output  1  latch memory read data into the instruction register.
pc_load  output  1  PC write enable.
pc_sel  output  2  0=PC+4, 1=PC+imm, 2=ALU result with bit 0 cleared.
rf_rs1  output  5  register_file rs1 address.
rf_rs2  output  5  register_file rs2 address.
rf_rd  output  5  register_file rd address.
rf_write  output  1  register_file write_register strobe.
alu_op  output  4  ALU operation code (alu_op_t).
alu_src_a  output  1  0=rs1v, 1=PC.
alu_src_b  output  1  0=rs2v, 1=imm.
wb_sel  output  2  0=ALU result, 1=load data, 2=PC+4.
imm  output  XLEN  sign-extended immediate for the current instr.
illegal  output  1  sticky: unsupported opcode seen.
bus_err  output  1  sticky: memory timeout.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. Reset state is FETCH.
- Reset values: every output 0, imm 0, timeout counter 0. The same values apply while in HALT, except the sticky flags.
- rst is sampled on posedge and overrides everything, including mid-MEM or mid-FETCH. mem_req drops on the cycle after rst is sampled, and the FSM returns to FETCH.
- FETCH: mem_req=1, mem_addr_sel=0. On mem_ready: ir_load=1 in the same cycle, then go to DECODE.
- DECODE: rf_rs1=instr[19:15], rf_rs2=instr[24:20]. register_file reads are registered, so rs1v/rs2v are valid in EXECUTE. Next state is EXECUTE.
- rf_rs1 and rf_rs2 hold the DECODE values through EXECUTE, MEM and WRITEBACK.
- EXECUTE, by opcode:
  - OP, OP-IMM, LUI, AUIPC: go to WRITEBACK.
  - LOAD, STORE: ALU computes rs1+imm; go to MEM.
  - BRANCH: pc_load=1, pc_sel = branch_taken ? 1 : 0; go to FETCH.
  - JAL: ALU computes PC+imm. JALR: ALU computes rs1+imm. Both go to WRITEBACK.
  - Any other opcode: set illegal, go to HALT.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. On mem_ready: a LOAD goes to WRITEBACK; a STORE asserts pc_load=1 with pc_sel=0 and goes to FETCH.
- WRITEBACK (exactly one cycle):
  - rf_rd=instr[11:7]; rf_write=1 only if rd!=0.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_load=1; pc_sel=2 for JAL/JALR, 0 otherwise.
  - Next state is FETCH.
- rf_write is asserted for the full WRITEBACK cycle so the register_file negedge write sees it stable.
- Handshake rules:
  - mem_req, mem_we and mem_addr_sel are stable from assertion until the cycle mem_ready=1 is sampled.
  - mem_ready outside FETCH/MEM is ignored.
  - mem_ready in the same cycle as mem_req rises completes the transfer (zero-wait).
- Timeout: the counter increments each waiting cycle and clears on every state change. If it reaches MEM_TIMEOUT (MEM_TIMEOUT!=0), set bus_err and go to HALT. mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT wins; no error is raised.
- HALT is left only by rst.
- Latency with zero-wait memory: ALU/JAL ops 4 cycles, branch 3, load 5, store 4.
- imm is combinational from instr, formatted per opcode (I/S/B/U/J), sign-extended to XLEN.

Decomposition:
- Package multicycle_pkg: state_t enum, opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), alu_op_t, pc_sel_t, wb_sel_t.
- One sub-module: imm_gen (combinational instr -> imm).

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 -> FETCH, DECODE, EXECUTE, WRITEBACK; rf_write=1 with rf_rd=1 and wb_sel=0 in cycle 4; imm=5.
- ADDI x0,x0,5 (0x00500013) -> rf_write stays 0 through WRITEBACK; pc_load=1 with pc_sel=0.
- LW x2,8(x1) (0x0080A103), mem_ready delayed 3 cycles in MEM -> mem_req and mem_addr_sel=1 held 4 cycles; WRITEBACK has rf_rd=2 and wb_sel=1.
- BEQ taken (0x00208463, branch_taken=1) -> pc_load=1, pc_sel=1 in EXECUTE, next state FETCH, no rf_write; imm=8.
- instr=0x00000000 -> illegal=1, FSM in HALT; it stays there despite mem_ready toggling until rst.
- mem_ready never asserted in FETCH with MEM_TIMEOUT=4 -> bus_err=1 after 4 wait cycles. Separately, rst asserted during MEM wait -> mem_req=0 the next cycle and the FSM is in FETCH.
